lcd_write_arbiter: RTL and testbench

Shares the single LCD_Driver write port between two independent requesters (e.g. a status-text generator and a counter/debug display). It round-robin arbitrates 18-bit display words, issues a line change to the driver when the granted word targets the other line, strobes the write, and waits for the driver to finish before granting again. It sits between the requesters and LCD_Driver, replacing the free-running refresh strobe with a handshake-driven one.

---
 rtl/lcd_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// lcd_write_arbiter : round-robin sharing of one LCD driver write port by two
//                     requesters, with line-change and busy handshake.
// Revision          : 1.0
// ============================================================================
module lcd_write_arbiter #(
  parameter int BUSY_TIMEOUT = 1023,
  parameter int GAP          = 3
) (
  input  logic        clk,
  input  logic        rstBt,
  input  logic        req0_valid,
  input  logic [17:0] req0_data,
  input  logic        req0_line,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [17:0] req1_data,
  input  logic        req1_line,
  output logic        req1_ready,
  output logic [17:0] drv_data,
  output logic        drv_write,
  output logic        drv_set_line,
  output logic        drv_line,
  input  logic        drv_busy,
  output logic        grant_id,
  output logic        busy,
  output logic        err_timeout
);

  localparam int c_TO_W  = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam int c_GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETLINE   = 3'd1,
    S_WRITE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP_WAIT  = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_ret_write;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_GAP_W-1:0]  r_gap_cnt;

  logic                w_pick1;
  logic                w_new_line;
  logic [17:0]         w_new_data;
  logic                w_op_done;

  // On a tie the requester that did not win last time is served.
  assign w_pick1    = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_new_line = w_pick1 ? req1_line : req0_line;
  assign w_new_data = w_pick1 ? req1_data : req0_data;
  assign w_op_done  = ~drv_busy &
                      (((r_state == S_WAIT_ACK) && (r_to_cnt == c_TO_LAST)) ||
                       (r_state == S_WAIT_DONE));

  always_ff @(posedge clk or negedge rstBt) begin
    if (!rstBt) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_ret_write  <= 1'b0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      drv_data     <= '0;
      drv_line     <= 1'b0;
      drv_write    <= 1'b0;
      drv_set_line <= 1'b0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      drv_write    <= 1'b0;
      drv_set_line <= 1'b0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_id     <= w_pick1;
            r_last_grant <= w_pick1;
            req0_ready   <= ~w_pick1;
            req1_ready   <= w_pick1;
            drv_data     <= w_new_data;
            busy         <= 1'b1;
            // The first strobe is registered here so it lands with ready.
            if (w_new_line != drv_line) begin
              drv_line     <= w_new_line;
              drv_set_line <= 1'b1;
              r_state      <= S_SETLINE;
            end else begin
              drv_write <= 1'b1;
              r_state   <= S_WRITE;
            end
          end
        end
        S_SETLINE: begin
          r_ret_write <= 1'b1;
          r_to_cnt    <= '0;
          r_state     <= S_WAIT_ACK;
        end
        S_WRITE: begin
          r_ret_write <= 1'b0;
          r_to_cnt    <= '0;
          r_state     <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (drv_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_to_cnt == c_TO_LAST) begin
            err_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
        end
        S_GAP_WAIT: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase

      // Completion of a driver operation (acknowledged or timed out).
      if (w_op_done) begin
        if (r_ret_write) begin
          drv_write <= 1'b1;
          r_state   <= S_WRITE;
        end else if (GAP == 0) begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end else begin
          r_gap_cnt <= '0;
          r_state   <= S_GAP_WAIT;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lcd_write_arbiter : directed vectors and corner sequences for the arbiter.
// Revision             : 1.0
// ============================================================================
module tb_lcd_write_arbiter;

  logic clk = 1'b0;
  logic rstBt = 1'b0;
  always #5 clk = ~clk;

  // Main instance: short busy timeout, default gap.
  logic        r0v = 1'b0, r0l = 1'b0, r1v = 1'b0, r1l = 1'b0;
  logic [17:0] r0d = '0, r1d = '0;
  logic        req0_ready, req1_ready, drv_write, drv_set_line, drv_line;
  logic        drv_busy, grant_id, busy, err_timeout;
  logic [17:0] drv_data;

  lcd_write_arbiter #(.BUSY_TIMEOUT(8), .GAP(3)) u_dut (
    .clk(clk), .rstBt(rstBt),
    .req0_valid(r0v), .req0_data(r0d), .req0_line(r0l), .req0_ready(req0_ready),
    .req1_valid(r1v), .req1_data(r1d), .req1_line(r1l), .req1_ready(req1_ready),
    .drv_data(drv_data), .drv_write(drv_write), .drv_set_line(drv_set_line),
    .drv_line(drv_line), .drv_busy(drv_busy), .grant_id(grant_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Second instance with no gap.
  logic        b_r0v = 1'b0, b_r1v = 1'b0;
  logic        b_req0_ready, b_req1_ready, b_drv_write, b_drv_set_line, b_drv_line;
  logic        b_drv_busy, b_grant_id, b_busy, b_err_timeout;
  logic [17:0] b_drv_data;

  lcd_write_arbiter #(.BUSY_TIMEOUT(1023), .GAP(0)) u_gap0 (
    .clk(clk), .rstBt(rstBt),
    .req0_valid(b_r0v), .req0_data(18'h00077), .req0_line(1'b0), .req0_ready(b_req0_ready),
    .req1_valid(b_r1v), .req1_data(18'h00099), .req1_line(1'b0), .req1_ready(b_req1_ready),
    .drv_data(b_drv_data), .drv_write(b_drv_write), .drv_set_line(b_drv_set_line),
    .drv_line(b_drv_line), .drv_busy(b_drv_busy), .grant_id(b_grant_id),
    .busy(b_busy), .err_timeout(b_err_timeout)
  );

  // Driver models: busy for a programmable number of cycles after any strobe.
  int a_blen = 4, a_bcnt = 0, b_bcnt = 0;
  always @(posedge clk or negedge rstBt) begin
    if (!rstBt) a_bcnt <= 0;
    else if (drv_write || drv_set_line) a_bcnt <= a_blen;
    else if (a_bcnt > 0) a_bcnt <= a_bcnt - 1;
  end
  always @(posedge clk or negedge rstBt) begin
    if (!rstBt) b_bcnt <= 0;
    else if (b_drv_write || b_drv_set_line) b_bcnt <= 20;
    else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
  end
  assign drv_busy   = (a_bcnt != 0);
  assign b_drv_busy = (b_bcnt != 0);

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0v;
    logic [17:0] r0d;
    logic        r0l;
    logic        r1v;
    logic [17:0] r1d;
    logic        r1l;
    int          blen;
    logic        e_gid;
    int          e_sl;
    logic [17:0] e_data;
    logic        e_line;
    int          e_busy;
  } vec_t;

  vec_t vecs [6];

  // Transaction observation results.
  int          s_rdy0, s_rdy1, s_wr, s_sl, s_busy, s_ovl, s_wr_idx, s_err_idx;
  logic [17:0] s_data;
  logic        s_gid;
  bit          s_done;

  // Watch one transaction from the grant edge until busy drops, then release valids.
  task automatic run_obs(input int bound);
    bit seen = 0;
    s_rdy0 = 0; s_rdy1 = 0; s_wr = 0; s_sl = 0; s_busy = 0; s_ovl = 0;
    s_wr_idx = -1; s_err_idx = -1; s_data = '0; s_gid = 1'b0; s_done = 0;
    for (int cyc = 0; cyc < bound; cyc++) begin
      @(negedge clk);
      if ((drv_write && drv_set_line) || (req0_ready && req1_ready)) s_ovl++;
      if (req0_ready || req1_ready) begin
        s_gid = grant_id;
        if (!(drv_write || drv_set_line)) s_ovl++;
      end
      if (req0_ready) s_rdy0++;
      if (req1_ready) s_rdy1++;
      if (drv_set_line) s_sl++;
      if (drv_write) begin
        s_wr++; s_data = drv_data; s_wr_idx = cyc;
      end
      if (err_timeout && s_err_idx < 0) s_err_idx = cyc;
      if (busy) begin
        s_busy++; seen = 1;
      end else if (seen) begin
        s_done = 1;
        break;
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    check("obs_complete", 32'(s_done), 32'd1);
  endtask

  logic [3:0] seq;
  int         n_gr, c0, c1, ovl;
  bit         cdone;
  int         k0, k1, kfall, rdy_in_busy;
  logic       id0, id1;
  bit         bseen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //                 r0v   r0d         r0l   r1v   r1d         r1l  B  gid   sl  data        line  busy
    vecs[0] = '{1'b1, 18'h0E38E, 1'b0, 1'b0, 18'h00000, 1'b0, 4, 1'b0, 0, 18'h0E38E, 1'b0, 9};
    vecs[1] = '{1'b0, 18'h00000, 1'b0, 1'b1, 18'h38E39, 1'b1, 4, 1'b1, 1, 18'h38E39, 1'b1, 15};
    vecs[2] = '{1'b1, 18'h12345, 1'b1, 1'b0, 18'h00000, 1'b0, 2, 1'b0, 0, 18'h12345, 1'b1, 7};
    vecs[3] = '{1'b1, 18'h0AAAA, 1'b0, 1'b1, 18'h15555, 1'b1, 1, 1'b1, 0, 18'h15555, 1'b1, 6};
    vecs[4] = '{1'b1, 18'h3FFFF, 1'b0, 1'b1, 18'h00001, 1'b1, 1, 1'b0, 1, 18'h3FFFF, 1'b0, 9};
    vecs[5] = '{1'b0, 18'h00000, 1'b0, 1'b1, 18'h2AAAA, 1'b0, 3, 1'b1, 0, 18'h2AAAA, 1'b0, 8};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_drv_data", 32'(drv_data), 32'd0);
    check("rst_drv_line", 32'(drv_line), 32'd0);
    check("rst_strobes", 32'({drv_write, drv_set_line, req0_ready, req1_ready}), 32'd0);
    rstBt = 1'b1;

    for (int i = 0; i < 6; i++) begin
      r0v = vecs[i].r0v; r0d = vecs[i].r0d; r0l = vecs[i].r0l;
      r1v = vecs[i].r1v; r1d = vecs[i].r1d; r1l = vecs[i].r1l;
      a_blen = vecs[i].blen;
      run_obs(100);
      check($sformatf("v%0d_gid", i), 32'(s_gid), 32'(vecs[i].e_gid));
      check($sformatf("v%0d_ready", i), 32'({s_rdy1[1:0], s_rdy0[1:0]}),
            vecs[i].e_gid ? 32'h4 : 32'h1);
      check($sformatf("v%0d_writes", i), 32'(s_wr), 32'd1);
      check($sformatf("v%0d_setline", i), 32'(s_sl), 32'(vecs[i].e_sl));
      check($sformatf("v%0d_data", i), 32'(s_data), 32'(vecs[i].e_data));
      check($sformatf("v%0d_line", i), 32'(drv_line), 32'(vecs[i].e_line));
      check($sformatf("v%0d_busy_cycles", i), 32'(s_busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_overlap", i), 32'(s_ovl), 32'd0);
    end

    // Contention: both requesters held valid for four grants.
    r0v = 1'b1; r0d = 18'h00F0F; r0l = 1'b0;
    r1v = 1'b1; r1d = 18'h3C3C3; r1l = 1'b1;
    a_blen = 1; seq = '0; n_gr = 0; c0 = 0; c1 = 0; ovl = 0; cdone = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if ((drv_write && drv_set_line) || (req0_ready && req1_ready)) ovl++;
      if (req0_ready || req1_ready) begin
        if (n_gr < 4) seq[n_gr] = grant_id;
        n_gr++;
        if (req0_ready) c0++;
        if (req1_ready) c1++;
      end
      if (n_gr >= 4) begin
        r0v = 1'b0; r1v = 1'b0;
        if (!busy) begin
          cdone = 1;
          break;
        end
      end
    end
    r0v = 1'b0; r1v = 1'b0;
    check("cont_complete", 32'(cdone), 32'd1);
    check("cont_order", 32'(seq), 32'hA);
    check("cont_ready0", 32'(c0), 32'd2);
    check("cont_ready1", 32'(c1), 32'd2);
    check("cont_overlap", 32'(ovl), 32'd0);

    // Timeout: driver never raises busy.
    check("to_err_before", 32'(err_timeout), 32'd0);
    r0v = 1'b1; r0d = 18'h01234; r0l = 1'b1; a_blen = 0;
    run_obs(100);
    check("to_busy_cycles", 32'(s_busy), 32'd12);
    check("to_err_delay", 32'(s_err_idx - s_wr_idx), 32'd9);
    check("to_err_set", 32'(err_timeout), 32'd1);

    // Good transfer afterwards keeps the sticky error.
    r1v = 1'b1; r1d = 18'h11111; r1l = 1'b1; a_blen = 2;
    run_obs(100);
    check("post_to_busy_cycles", 32'(s_busy), 32'd7);
    check("post_to_gid", 32'(s_gid), 32'd1);
    check("post_to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset during WAIT_DONE with req0 still valid.
    r0v = 1'b1; r0d = 18'h05A5A; r0l = 1'b1; a_blen = 20;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (drv_write) break;
    end
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #1 rstBt = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(drv_data), 32'd0);
    check("mid_rst_line", 32'(drv_line), 32'd0);
    check("mid_rst_err", 32'(err_timeout), 32'd0);
    check("mid_rst_gid", 32'(grant_id), 32'd0);
    check("mid_rst_strobes", 32'({drv_write, drv_set_line, req0_ready, req1_ready}), 32'd0);
    a_blen = 2;
    @(negedge clk);
    rstBt = 1'b1;
    run_obs(100);
    check("mid_regrant_ready", 32'({s_rdy1[1:0], s_rdy0[1:0]}), 32'h1);
    check("mid_regrant_setline", 32'(s_sl), 32'd1);
    check("mid_regrant_line", 32'(drv_line), 32'd1);
    check("mid_regrant_data", 32'(s_data), 32'h05A5A);
    check("mid_regrant_busy_cycles", 32'(s_busy), 32'd11);
    check("mid_regrant_overlap", 32'(s_ovl), 32'd0);

    // No-gap instance with a 20-cycle driver operation.
    b_r0v = 1'b1; b_r1v = 1'b1;
    k0 = -1; k1 = -1; kfall = -1; rdy_in_busy = 0; bseen = 0; id0 = 1'b0; id1 = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (b_drv_busy) bseen = 1;
      else if (bseen && kfall < 0) kfall = cyc;
      if (b_req0_ready || b_req1_ready) begin
        if (b_drv_busy) rdy_in_busy++;
        if (k0 < 0) begin
          k0 = cyc; id0 = b_req1_ready;
        end else begin
          k1 = cyc; id1 = b_req1_ready;
          break;
        end
      end
    end
    b_r0v = 1'b0; b_r1v = 1'b0;
    check("gap0_first_id", 32'(id0), 32'd0);
    check("gap0_second_id", 32'(id1), 32'd1);
    check("gap0_ready_while_busy", 32'(rdy_in_busy), 32'd0);
    check("gap0_fall_seen", 32'(kfall >= 0), 32'd1);
    check("gap0_regrant_delay", 32'(k1 - kfall), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
